// File: rtl/alu_pkg.sv
// Shared ALU op encodings and the multiply sequencer state type.
package alu_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0011;
    localparam logic [3:0] ALU_SUB  = 4'b0111;
    localparam logic [3:0] ALU_DBL  = 4'b1011;
    localparam logic [3:0] ALU_OR   = 4'b1100;
    localparam logic [3:0] ALU_AND  = 4'b1101;
    localparam logic [3:0] ALU_EOR  = 4'b1110;
    localparam logic [3:0] ALU_PASS = 4'b1111;

    typedef enum logic [2:0] {
        IDLE,
        ADD,
        RORH,
        RORL,
        WB,
        DONE
    } seq_state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Unsigned 8x8->16 shift-and-add multiplier that borrows the shared 8-bit ALU;
// ALU registered results are forwarded combinationally into the next issue.
module alu_mul_seq
    import alu_pkg::*;
#(
    parameter bit SKIP_ZERO = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        rdy,
    input  logic        start,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic        busy,
    output logic        done,
    output logic [15:0] product,
    output logic [3:0]  alu_op,
    output logic        alu_right,
    output logic [7:0]  alu_ai,
    output logic [7:0]  alu_bi,
    output logic        alu_ci,
    output logic        alu_bcd,
    output logic        alu_rdy,
    input  logic [7:0]  alu_out,
    input  logic        alu_co
);

    seq_state_t  state_q, state_d;
    logic [7:0]  mcand_q, mcand_d;
    logic [7:0]  hi_q, hi_d;
    logic [7:0]  lo_q, lo_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [15:0] product_q, product_d;
    logic        dec_q, dec_d;
    logic        add_q, add_d;
    logic        mbit;
    logic        take_add;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            cnt_q     <= '0;
            product_q <= '0;
            dec_q     <= 1'b0;
            add_q     <= 1'b0;
        end else if (rdy) begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            dec_q     <= dec_d;
            add_q     <= add_d;
        end
    end

    // After RORL the rotated multiplier is still in the ALU, so its low bit is read from alu_out.
    assign mbit     = dec_q ? alu_out[0] : lo_q[0];
    assign take_add = mbit || !SKIP_ZERO;

    assign product = product_q;
    assign alu_bcd = 1'b0;
    assign alu_rdy = rdy;

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        dec_d     = 1'b0;
        add_d     = 1'b0;
        alu_op    = ALU_PASS;
        alu_right = 1'b0;
        alu_ai    = '0;
        alu_bi    = '0;
        alu_ci    = 1'b0;
        busy      = (state_q != IDLE);
        done      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    mcand_d = a;
                    hi_d    = '0;
                    lo_d    = b;
                    cnt_d   = '0;
                    state_d = (b[0] || !SKIP_ZERO) ? ADD : RORH;
                end
            end
            ADD: begin
                if (dec_q) begin
                    lo_d = alu_out;
                end
                // A skipped add in the decode cycle issues the plain RORH here instead.
                if (take_add) begin
                    alu_op  = mbit ? ALU_ADD : ALU_PASS;
                    alu_ai  = hi_q;
                    alu_bi  = mbit ? mcand_q : 8'h00;
                    add_d   = 1'b1;
                    state_d = RORH;
                end else begin
                    alu_right = 1'b1;
                    alu_ai    = hi_q;
                    state_d   = RORL;
                end
            end
            RORH: begin
                alu_right = 1'b1;
                alu_ai    = add_q ? alu_out : hi_q;
                alu_ci    = add_q && alu_co;
                state_d   = RORL;
            end
            RORL: begin
                hi_d      = alu_out;
                alu_right = 1'b1;
                alu_ai    = lo_q;
                alu_ci    = alu_co;
                if (cnt_q == 3'd7) begin
                    state_d = WB;
                end else begin
                    cnt_d   = cnt_q + 3'd1;
                    dec_d   = 1'b1;
                    state_d = ADD;
                end
            end
            WB: begin
                lo_d      = alu_out;
                product_d = {hi_q, alu_out};
                state_d   = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Bench for alu_mul_seq: two sequencers (SKIP_ZERO=1 and 0), each with its own ALU model.
module tb_alu_mul_seq;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       rdy = 1'b1;
    logic       start = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;

    logic        busy0, done0, right0, ci0, bcd0, ardy0;
    logic [15:0] prod0;
    logic [3:0]  op0;
    logic [7:0]  ai0, bi0;
    logic [7:0]  aout0 = '0;
    logic        aco0 = 1'b0;

    logic        busy1, done1, right1, ci1, bcd1, ardy1;
    logic [15:0] prod1;
    logic [3:0]  op1;
    logic [7:0]  ai1, bi1;
    logic [7:0]  aout1 = '0;
    logic        aco1 = 1'b0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_mul_seq #(.SKIP_ZERO(1'b1)) dut0 (
        .clk(clk), .reset_n(reset_n), .rdy(rdy), .start(start), .a(a), .b(b),
        .busy(busy0), .done(done0), .product(prod0),
        .alu_op(op0), .alu_right(right0), .alu_ai(ai0), .alu_bi(bi0), .alu_ci(ci0),
        .alu_bcd(bcd0), .alu_rdy(ardy0), .alu_out(aout0), .alu_co(aco0)
    );

    alu_mul_seq #(.SKIP_ZERO(1'b0)) dut1 (
        .clk(clk), .reset_n(reset_n), .rdy(rdy), .start(start), .a(a), .b(b),
        .busy(busy1), .done(done1), .product(prod1),
        .alu_op(op1), .alu_right(right1), .alu_ai(ai1), .alu_bi(bi1), .alu_ci(ci1),
        .alu_bcd(bcd1), .alu_rdy(ardy1), .alu_out(aout1), .alu_co(aco1)
    );

    // Registered ALU behaviour for the ops the sequencer uses: {co, out}.
    function automatic logic [8:0] alu_f(input logic [3:0] op, input logic right,
                                         input logic [7:0] ai, input logic [7:0] bi,
                                         input logic ci);
        logic [8:0] r;
        if (right) begin
            r = {ai[0], ci, ai[7:1]};
        end else begin
            case (op)
                4'b0011: r = {1'b0, ai} + {1'b0, bi} + {8'h00, ci};
                4'b0111: r = {1'b0, ai} + {1'b0, ~bi} + {8'h00, ci};
                default: r = {1'b0, ai};
            endcase
        end
        return r;
    endfunction

    always @(posedge clk) begin
        if (ardy0) {aco0, aout0} <= alu_f(op0, right0, ai0, bi0, ci0);
        if (ardy1) {aco1, aout1} <= alu_f(op1, right1, ai1, bi1, ci1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One multiply on both DUTs; cycle c is the c-th falling edge after the accepting edge.
    task automatic do_op(input logic [7:0] va, input logic [7:0] vb, input logic [15:0] exp_p,
                         input int lat0, input int stall_at, input int stall_n,
                         input string name);
        int d0, d1, n0, n1;
        logic [63:0] snap;
        d0 = -1; d1 = -1; n0 = 0; n1 = 0; snap = '0;
        @(negedge clk);
        a = va; b = vb; start = 1'b1;
        for (int c = 1; c <= 45 + stall_n; c++) begin
            @(negedge clk);
            if (c == 1) begin
                start = 1'b0; a = '0; b = '0;
                check({name, "_busy"}, {busy0, busy1}, 2'b11);
            end
            if (done0) begin n0++; if (d0 < 0) d0 = c; end
            if (done1) begin n1++; if (d1 < 0) d1 = c; end
            if (stall_n > 0) begin
                if (c == stall_at) begin
                    snap = {13'd0, busy0, op0, right0, ai0, bi0, ci0, prod0, op1, ai1};
                    check({name, "_rorh"}, right0, 1'b1);
                end else if (c > stall_at && c <= stall_at + stall_n) begin
                    check({name, "_frozen"},
                          {13'd0, busy0, op0, right0, ai0, bi0, ci0, prod0, op1, ai1}, snap);
                    if (c == stall_at + 1) check({name, "_alu_rdy"}, ardy0, 1'b0);
                end
            end
            rdy = !(stall_n > 0 && c >= stall_at && c < stall_at + stall_n);
        end
        rdy = 1'b1;
        check({name, "_prod0"}, prod0, exp_p);
        check({name, "_prod1"}, prod1, exp_p);
        check({name, "_lat0"}, d0, lat0 + stall_n);
        check({name, "_lat1"}, d1, 26 + stall_n);
        check({name, "_pulses0"}, n0, 1);
        check({name, "_pulses1"}, n1, 1);
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while ((busy0 || busy1) && k < 100) begin
            @(negedge clk);
            k++;
        end
        check({name, "_idle"}, {busy0, busy1}, 2'b00);
    endtask

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] p;
        int          lat;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int f0[2], f1[2], k0, k1, n;
        vecs[0] = '{8'h0D, 8'h0B, 16'h008F, 21};
        vecs[1] = '{8'hFF, 8'hFF, 16'hFE01, 26};
        vecs[2] = '{8'h00, 8'hFF, 16'h0000, 26};
        vecs[3] = '{8'h5A, 8'h00, 16'h0000, 18};
        vecs[4] = '{8'h80, 8'h01, 16'h0080, 19};
        vecs[5] = '{8'h01, 8'h80, 16'h0080, 19};
        vecs[6] = '{8'hC3, 8'hA5, 16'h7DAF, 22};
        vecs[7] = '{8'h55, 8'hAA, 16'h3872, 22};

        repeat (3) @(negedge clk);
        check("reset_state0", {busy0, done0, prod0, op0, right0, ai0, bi0, ci0, bcd0},
              {2'b00, 16'h0000, 4'hF, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0});
        check("reset_state1", {busy1, done1, prod1, op1, right1, ai1, bi1, ci1, bcd1},
              {2'b00, 16'h0000, 4'hF, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0});
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].p, vecs[i].lat, 0, 0, $sformatf("v%0d", i));
        end

        do_op(8'h37, 8'h91, 16'h1F27, 21, 8, 5, "stall");

        // Start held high: accepts at edges 0, 20, 40 for SKIP_ZERO=1; 0, 27 otherwise.
        f0 = '{-1, -1}; f1 = '{-1, -1}; k0 = 0; k1 = 0;
        @(negedge clk);
        a = 8'h10; b = 8'h10; start = 1'b1;
        for (int c = 1; c <= 56; c++) begin
            @(negedge clk);
            if (done0) begin
                if (k0 < 2) f0[k0] = c;
                k0++;
                check("held_prod0", prod0, 16'h0100);
            end
            if (done1) begin
                if (k1 < 2) f1[k1] = c;
                k1++;
                check("held_prod1", prod1, 16'h0100);
            end
            if (c == 20) check("held_idle_gap", busy0, 1'b0);
        end
        start = 1'b0;
        check("held_first0", f0[0], 19);
        check("held_second0", f0[1], 39);
        check("held_first1", f1[0], 26);
        check("held_second1", f1[1], 53);
        wait_idle("held");

        // Reset at cycle 10 of an operation drops it.
        n = 0;
        @(negedge clk);
        a = 8'hFF; b = 8'hFF; start = 1'b1;
        for (int c = 1; c <= 45; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            if (done0 || done1) n++;
            if (c == 10) reset_n = 1'b0;
            if (c == 11) begin
                reset_n = 1'b1;
                check("midreset_state0", {busy0, prod0, op0, right0, ai0, bi0, ci0},
                      {1'b0, 16'h0000, 4'hF, 1'b0, 8'h00, 8'h00, 1'b0});
                check("midreset_busy1", busy1, 1'b0);
            end
        end
        check("midreset_no_done", n, 0);

        do_op(8'h02, 8'h03, 16'h0006, 20, 0, 0, "after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
